instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Decoupled instruction-fetch front end that owns the PC, issues word requests to a variable-latency instruction memory over a valid/ready handshake, and buffers returned instructions in a small in-order queue. It sits directly upstream of the IF/ID register of the 5-stage pipeline. The pipeline pops one instruction per cycle when its IF/ID write enable is high, and redirects the unit on taken branches and jumps. Stale in-flight responses are discarded after a redirect.

## Interface
- `TEXT`, default 32'h0040_0000: PC value after reset.
- `DEPTH`, default 4: queue entries, and also the maximum outstanding requests plus queued instructions. Power of two, 2..16.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low. One clock, synchronous active-low reset.
- `imem_req_valid` out 1: fetch request is valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word address; bits [1:0] are always 0.
- `imem_rsp_valid` in 1: response is valid. Responses are in order, one per accepted request, and arrive 1 or more cycles after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `fetch_valid` out 1: head of the queue is valid.
- `fetch_ready` in 1: pipeline consumes the head (driven by IF/ID write).
- `fetch_instr` out 32: head instruction, or NOP 32'h0000_0033 when not valid.
- `fetch_pc` out 32: PC of the head instruction, or 0 when not valid.
- `redirect_valid` in 1: branch or jump taken.
- `redirect_pc` in 32: new fetch target; bits [1:0] are ignored and forced to 0.

## Operation
- State machine with three states: BOOT, RUN, DRAIN.
  - BOOT: entered on reset and held for 1 cycle, with no requests. Always goes to RUN.
  - RUN: normal fetching.
  - DRAIN: waits until all stale responses have been discarded. No requests are issued.
- Counters:
  - `out_cnt`: outstanding requests, 0..DEPTH.
  - `q_cnt`: queue occupancy, 0..DEPTH.
  - `discard_cnt`: responses still to drop, 0..DEPTH.
- Credit rule: `imem_req_valid` = (state==RUN) && (out_cnt + q_cnt < DEPTH) && !redirect_valid. The queue therefore can never overflow.
- Request accepted (valid && ready): pc += 4 (32-bit wrap), out_cnt++.
- Response handling:
  - Every response decrements out_cnt.
  - If discard_cnt > 0 (or redirect_valid is high in the same cycle), the response is dropped. A drop under discard_cnt decrements discard_cnt.
  - Otherwise {pc_of_entry, data} is pushed to the queue. The entry PC comes from a parallel in-flight PC queue, or is computed as the head PC plus 4 times the entry offset.
- Pop: fetch_valid && fetch_ready removes the head.
- Redirect, which has the highest priority:
  - The queue is flushed and a pop in the same cycle is ignored.
  - No request is issued that cycle.
  - discard_cnt <= out_cnt − imem_rsp_valid.
  - pc <= redirect_pc & ~3.
  - Next state is RUN if the new discard_cnt is 0, otherwise DRAIN.
  - A redirect while in DRAIN updates pc and recomputes discard_cnt by the same rule.
  - A redirect while in BOOT updates pc only.
- DRAIN → RUN on the cycle discard_cnt reaches 0. The first request is issued in the following cycle.
- Responses while out_cnt==0 are a protocol error. They are ignored and do not underflow any counter.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=TEXT, fetch_valid=0, fetch_instr=32'h33, fetch_pc=0, pc=TEXT, all counters 0, state BOOT.
- The instruction memory shares reset_n. A reset asserted mid-operation abandons all in-flight requests with no discards carried over.
- First request: the cycle after reset_n is released plus 1 (BOOT).
- Response in cycle N → fetch_valid in cycle N+1. The queue is registered, with no same-cycle bypass.
- Sustained throughput is 1 instruction per cycle when memory latency ≤ DEPTH−1 and fetch_ready is held high.
- Queue full with fetch_ready=0: requests stop. With a push and a pop in the same cycle, q_cnt is unchanged.
- A redirect in cycle N makes the first new request visible in N+1 (when discard_cnt=0). Its instruction reaches fetch_valid no earlier than N+3.

## Structure
- Shared package (alongside TEXT and the FORWARD_*/PC* constants):
  - NOP constant 32'h0000_0033.
  - Fetch state enum {BOOT, RUN, DRAIN}.
  - Default DEPTH.
- One sub-module, `fetch_queue`:
  - Parameterised synchronous FIFO of {pc[31:0], instr[31:0]}.
  - Ports: push, pop, flush, count, head.
  - Wrap-around read/write pointers with an extra MSB for the full/empty distinction.

## Test plan
- Reset and boot: release reset_n. Expect imem_req_addr=32'h0040_0000 two cycles later, and fetch_instr=32'h33 with fetch_valid=0 until the first response.
- Streaming: memory with latency 1, always ready, fetch_ready=1. Expect fetch_pc sequence 0x400000, 0x400004, 0x400008… one per cycle with no bubbles.
- Backpressure: fetch_ready=0 for 10 cycles. Expect exactly DEPTH=4 requests then imem_req_valid=0. Releasing fetch_ready yields the 4 instructions in order.
- Redirect with 3 in flight: latency 3, redirect_pc=0x400100. Expect 3 responses dropped, state DRAIN, and the next fetch_pc=0x400100 with no stale instruction ever shown.
- Redirect during DRAIN to 0x400200, with redirect_pc=0x400203 misaligned. Expect fetching to resume at 0x400200 only, and discard_cnt never to underflow.
- Mid-operation reset: reset_n low for 1 cycle with a full queue and 2 outstanding requests. Expect all outputs back to reset values and refetch from TEXT.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg
//   Shared constants and types for the fetch front end of the 5-stage
//   pipeline: reset PC, NOP encoding, PC arithmetic constants, forwarding
//   select codes, fetch FSM state enum and the queue entry layout.
package instruction_fetch_unit_pkg;

   localparam logic [31:0] TEXT_BASE     = 32'h0040_0000;
   localparam logic [31:0] NOP           = 32'h0000_0033;
   localparam logic [31:0] PC_STEP       = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   localparam logic [1:0] FORWARD_NONE = 2'b00;
   localparam logic [1:0] FORWARD_MEM  = 2'b01;
   localparam logic [1:0] FORWARD_EX   = 2'b10;

   localparam int unsigned DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue
//   Synchronous in-order FIFO of {pc, instr} entries.
//   Ports: clock, reset_n (sync, active-low), push/push_data write an entry,
//   pop removes the head, flush empties the queue (wins over push/pop),
//   count is the occupancy 0..DEPTH, head is the oldest entry (undefined
//   contents when count is 0).
module fetch_queue
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      push,
   input  fetch_entry_t              push_data,
   input  logic                      pop,
   input  logic                      flush,
   output logic [$clog2(DEPTH):0]    count,
   output fetch_entry_t              head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   fetch_entry_t mem [DEPTH];
   // Pointers carry one extra MSB so full (count == DEPTH) and empty differ.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge clock) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_comb begin
      count = wr_ptr - rd_ptr;
      head  = mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Decoupled fetch front end: owns the PC, issues word requests to a
//   variable-latency instruction memory and queues returned instructions
//   for the IF/ID register. Redirects flush the queue and drop responses
//   still in flight from the old path.
//   Ports:
//     clock, reset_n                 clock and sync active-low reset
//     imem_req_valid/ready/addr      request channel (word address)
//     imem_rsp_valid/data            in-order response channel
//     fetch_valid/ready/instr/pc     queue head towards IF/ID (NOP/0 when empty)
//     redirect_valid/pc              taken branch / jump target
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] TEXT  = TEXT_BASE,
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_instr,
   output logic [31:0] fetch_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned CW    = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] ONE = CW'(1);
   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

   fetch_state_t  state;
   fetch_state_t  state_next;
   logic [31:0]   pc;
   logic [31:0]   pc_next;
   logic [31:0]   rsp_pc;
   logic [31:0]   rsp_pc_next;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] out_cnt_next;
   logic [CW-1:0] discard_cnt;
   logic [CW-1:0] discard_cnt_next;
   logic [CW-1:0] q_cnt;
   logic [CW:0]   credit_used;
   logic [31:0]   redirect_target;
   logic          req_fire;
   logic          rsp_fire;
   logic          drop;
   logic          push;
   logic          pop;
   fetch_entry_t  push_data;
   fetch_entry_t  head;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (q_cnt),
      .head      (head)
   );

   always_comb begin
      redirect_target = redirect_pc & PC_ALIGN_MASK;
      credit_used     = {1'b0, out_cnt} + {1'b0, q_cnt};
      fetch_valid     = (q_cnt != '0);
      fetch_instr     = fetch_valid ? head.instr : NOP;
      fetch_pc        = fetch_valid ? head.pc : '0;
      imem_req_addr   = pc;

      // Outstanding requests plus queued entries never exceed DEPTH, so
      // every response always has a queue slot.
      imem_req_valid = (state == RUN) && (credit_used < LIMIT) && !redirect_valid;
      req_fire       = imem_req_valid && imem_req_ready;
      // A response with nothing outstanding is a protocol error: ignored.
      rsp_fire       = imem_rsp_valid && (out_cnt != '0);
      drop           = rsp_fire && ((discard_cnt != '0) || redirect_valid);
      push           = rsp_fire && !drop;
      pop            = fetch_valid && fetch_ready && !redirect_valid;
      // Responses return in order, so the PC of the next kept response is a
      // running counter instead of a parallel in-flight PC queue.
      push_data      = {rsp_pc, imem_rsp_data};

      state_next       = state;
      pc_next          = pc;
      rsp_pc_next      = rsp_pc;
      out_cnt_next     = out_cnt + (req_fire ? ONE : '0) - (rsp_fire ? ONE : '0);
      discard_cnt_next = discard_cnt;

      if (rsp_fire && (discard_cnt != '0)) discard_cnt_next = discard_cnt - ONE;
      if (req_fire) pc_next = pc + PC_STEP;
      if (push)     rsp_pc_next = rsp_pc + PC_STEP;

      case (state)
         BOOT:    state_next = RUN;
         RUN:     state_next = RUN;
         DRAIN:   if (discard_cnt_next == '0) state_next = RUN;
         default: state_next = BOOT;
      endcase

      if (redirect_valid) begin
         pc_next     = redirect_target;
         rsp_pc_next = redirect_target;
         if (state != BOOT) begin
            discard_cnt_next = out_cnt - (rsp_fire ? ONE : '0);
            state_next       = (discard_cnt_next == '0) ? RUN : DRAIN;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= BOOT;
         pc          <= TEXT;
         rsp_pc      <= TEXT;
         out_cnt     <= '0;
         discard_cnt <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         rsp_pc      <= rsp_pc_next;
         out_cnt     <= out_cnt_next;
         discard_cnt <= discard_cnt_next;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit: reset/boot, backpressure,
//   streaming, redirect with stale responses, redirect during DRAIN and a
//   mid-operation reset. The memory returns ~addr as the instruction word.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   logic        clock;
   logic        reset_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   instruction_fetch_unit #(
      .TEXT  (32'h0040_0000),
      .DEPTH (4)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_instr    (fetch_instr),
      .fetch_pc       (fetch_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned fails  = 0;

   logic [31:0] mq_addr [$];
   int unsigned mq_due [$];
   int unsigned cyc = 0;
   int unsigned lat = 1;
   logic        rsp_from_model = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] exp_pc = '0;
   int unsigned n_acc = 0;
   int unsigned n_pop = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, update the memory model
   // after it, then present the next response (if due).
   task automatic tick();
      logic        acc;
      logic [31:0] acc_addr;
      logic        took;
      logic        pop_seen;
      logic [31:0] pop_pc;
      logic [31:0] pop_instr;
      acc       = imem_req_valid && imem_req_ready;
      acc_addr  = imem_req_addr;
      took      = rsp_from_model && imem_rsp_valid;
      pop_seen  = mon_en && fetch_valid && fetch_ready && !redirect_valid;
      pop_pc    = fetch_pc;
      pop_instr = fetch_instr;
      @(posedge clock);
      #1;
      cyc++;
      if (!reset_n) begin
         mq_addr.delete();
         mq_due.delete();
      end else begin
         if (acc) begin
            mq_addr.push_back(acc_addr);
            mq_due.push_back(cyc + lat - 1);
            n_acc++;
         end
         if (took) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
         end
      end
      if (pop_seen) begin
         check("pop_pc", pop_pc, exp_pc);
         check("pop_instr", pop_instr, ~exp_pc);
         exp_pc = exp_pc + 32'd4;
         n_pop++;
      end
      rsp_from_model = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mq_addr.size() > 0 && reset_n) begin
         if (mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq_addr[0];
            rsp_from_model = 1'b1;
         end
      end
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0040_0000);
      check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      check("rst_fetch_instr", fetch_instr, 32'h0000_0033);
      check("rst_fetch_pc", fetch_pc, 32'd0);
      check("rst_state", 32'(dut.state), 32'(BOOT));
      check("rst_out_cnt", 32'(dut.out_cnt), 32'd0);
   endtask

   // Leaves the bench in the BOOT cycle right after reset release.
   task automatic do_reset(input int unsigned l, input logic fr);
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      fetch_ready    = fr;
      lat            = l;
      mon_en         = 1'b0;
      tick();
      tick();
      check_reset_outputs();
      reset_n = 1'b1;
      n_acc   = 0;
      n_pop   = 0;
      #1;
      check("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
   endtask

   initial begin
      reset_n        = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      fetch_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Boot, spurious response, backpressure (latency 1, fetch_ready low)
      do_reset(1, 1'b0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      rsp_from_model = 1'b0;
      tick();
      check("spurious_out_cnt", 32'(dut.out_cnt), 32'd0);
      check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0040_0000);
      check("first_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      check("first_fetch_instr", fetch_instr, 32'h0000_0033);
      tick();
      check("rsp_cycle_not_bypassed", {31'b0, fetch_valid}, 32'd0);
      check("rsp_cycle_pc", fetch_pc, 32'd0);
      repeat (8) tick();
      check("bp_req_count", n_acc, 32'd4);
      check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("bp_fetch_valid", {31'b0, fetch_valid}, 32'd1);
      check("bp_head_pc", fetch_pc, 32'h0040_0000);
      check("bp_head_instr", fetch_instr, 32'hFFBF_FFFF);

      // Release backpressure: queued four in order, then bubble-free stream
      mon_en      = 1'b1;
      exp_pc      = 32'h0040_0000;
      fetch_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("stream_valid", {31'b0, fetch_valid}, 32'd1);
      end
      check("stream_pops", n_pop, 32'd12);

      // Redirect with three requests in flight (latency 3)
      do_reset(3, 1'b1);
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0100;
      #1;
      check("redir_blocks_req", {31'b0, imem_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("redir_state_drain", 32'(dut.state), 32'(DRAIN));
      check("redir_discard2", 32'(dut.discard_cnt), 32'd2);
      check("redir_flushed", {31'b0, fetch_valid}, 32'd0);
      check("drain_no_req", {31'b0, imem_req_valid}, 32'd0);
      tick();
      check("drain_state", 32'(dut.state), 32'(DRAIN));
      check("drain_discard1", 32'(dut.discard_cnt), 32'd1);
      check("drain_hidden", {31'b0, fetch_valid}, 32'd0);
      tick();
      check("drain_exit_run", 32'(dut.state), 32'(RUN));
      check("drain_exit_discard", 32'(dut.discard_cnt), 32'd0);
      check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("redir_req_addr", imem_req_addr, 32'h0040_0100);
      mon_en = 1'b1;
      exp_pc = 32'h0040_0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_stale_valid", {31'b0, fetch_valid}, 32'd0);
      end
      tick();
      check("redir_first_valid", {31'b0, fetch_valid}, 32'd1);
      check("redir_first_pc", fetch_pc, 32'h0040_0100);
      repeat (4) tick();

      // Redirect while draining, misaligned target
      do_reset(3, 1'b1);
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0040_0100;
      tick();
      redirect_pc = 32'h0040_0203;
      #1;
      check("redir2_blocks_req", {31'b0, imem_req_valid}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("redir2_state", 32'(dut.state), 32'(DRAIN));
      check("redir2_discard1", 32'(dut.discard_cnt), 32'd1);
      tick();
      check("redir2_run", 32'(dut.state), 32'(RUN));
      check("redir2_req_addr", imem_req_addr, 32'h0040_0200);
      check("redir2_req_valid", {31'b0, imem_req_valid}, 32'd1);
      mon_en = 1'b1;
      exp_pc = 32'h0040_0200;
      tick();
      check("redir2_no_underflow", 32'(dut.discard_cnt), 32'd0);
      repeat (2) tick();
      tick();
      check("redir2_first_valid", {31'b0, fetch_valid}, 32'd1);
      check("redir2_first_pc", fetch_pc, 32'h0040_0200);
      repeat (3) tick();

      // Mid-operation reset with queued and outstanding work
      do_reset(3, 1'b0);
      repeat (6) tick();
      check("pre_rst_out_cnt", 32'(dut.out_cnt), 32'd2);
      check("pre_rst_q_cnt", 32'(dut.q_cnt), 32'd2);
      check("pre_rst_head", fetch_pc, 32'h0040_0000);
      reset_n = 1'b0;
      tick();
      check_reset_outputs();
      reset_n     = 1'b1;
      fetch_ready = 1'b1;
      #1;
      check("reboot_no_req", {31'b0, imem_req_valid}, 32'd0);
      mon_en = 1'b1;
      exp_pc = 32'h0040_0000;
      tick();
      check("refetch_valid", {31'b0, imem_req_valid}, 32'd1);
      check("refetch_addr", imem_req_addr, 32'h0040_0000);
      repeat (4) tick();
      check("refetch_fetch_valid", {31'b0, fetch_valid}, 32'd1);
      check("refetch_fetch_pc", fetch_pc, 32'h0040_0000);
      repeat (4) tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
